// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the fetch/MEM RAM arbiter.
// Bus widths, FSM encoding and default RAM timing.
package mem_arbiter_pkg;

  localparam int InstAddrBus = 16;
  localparam int RegBus = 16;
  localparam int MEM_WAIT_DEFAULT = 1;

  typedef logic [InstAddrBus-1:0] addr_t;
  typedef logic [RegBus-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEM_ACC = 2'd1,
    IF_ACC  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arb_fetch_buf.sv
// One-entry fetch buffer holding the last fetched address/instruction.
// Instantiated only when MEM_ARB_FETCH_BUF_EN is defined.
module mem_arb_fetch_buf
  import mem_arbiter_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  fill,
  input  addr_t fill_addr,
  input  word_t fill_data,
  input  logic  inval,
  input  addr_t inval_addr,
  input  addr_t lookup_addr,
  output logic  hit,
  output word_t data
);

  addr_t buf_addr;
  word_t buf_data;
  logic  buf_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_addr  <= '0;
      buf_data  <= '0;
      buf_valid <= 1'b0;
    end else if (fill) begin
      buf_addr  <= fill_addr;
      buf_data  <= fill_data;
      buf_valid <= 1'b1;
    end else if (inval && inval_addr == buf_addr) begin
      buf_valid <= 1'b0;
    end
  end

  assign hit  = buf_valid && (buf_addr == lookup_addr);
  assign data = buf_data;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one RAM between instruction fetch and MEM-stage accesses.
// Define MEM_ARB_FETCH_BUF_EN to add a one-entry fetch buffer.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WAIT_CYCLES = MEM_WAIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_ce_i,
  input  logic [15:0] if_addr_i,
  output logic [15:0] if_inst_o,
  output logic        if_valid_o,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [15:0] mem_addr_i,
  input  logic [15:0] mem_data_i,
  output logic [15:0] mem_data_o,
  output logic        mem_done_o,
  output logic        stallreq_o,
  output logic [15:0] ram_addr_o,
  output logic [15:0] ram_data_o,
  input  logic [15:0] ram_data_i,
  output logic        ram_oe_o,
  output logic        ram_we_o
);

  localparam logic [2:0] CNT_INIT = 3'(WAIT_CYCLES);

  arb_state_t state_q, state_d;
  logic [2:0] cnt_q;
  logic       served_q;
  addr_t      addr_q;
  word_t      wdata_q;
  logic       we_q;
  logic       pend_mem;
  logic       last;
  logic       stall;
  logic       buf_hit;
  word_t      buf_data;

  assign pend_mem = mem_ce_i && !served_q;
  assign last     = (cnt_q == 3'd0);

`ifdef MEM_ARB_FETCH_BUF_EN
  mem_arb_fetch_buf u_fetch_buf (
    .clk        (clk),
    .rst        (rst),
    .fill       (state_q == IF_ACC && last),
    .fill_addr  (addr_q),
    .fill_data  (ram_data_i),
    .inval      (state_q == MEM_ACC && last && we_q),
    .inval_addr (addr_q),
    .lookup_addr(if_addr_i),
    .hit        (buf_hit),
    .data       (buf_data)
  );
`else
  assign buf_hit  = 1'b0;
  assign buf_data = '0;
`endif

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pend_mem) begin
          state_d = MEM_ACC;
          stall   = 1'b1;
        end else if (if_ce_i && !buf_hit) begin
          state_d = IF_ACC;
          stall   = 1'b1;
        end
      end
      MEM_ACC: begin
        stall = 1'b1;
        if (last) state_d = if_ce_i ? IF_ACC : IDLE;
      end
      IF_ACC: begin
        stall = !last;
        if (last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      served_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      if_inst_o  <= '0;
      mem_data_o <= '0;
      if_valid_o <= 1'b0;
      mem_done_o <= 1'b0;
    end else begin
      state_q    <= state_d;
      if_valid_o <= 1'b0;
      mem_done_o <= 1'b0;
      // A cycle without stall means the pipeline moved on.
      if (!stall) served_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pend_mem) begin
            addr_q  <= mem_addr_i;
            we_q    <= mem_we_i;
            wdata_q <= mem_data_i;
            cnt_q   <= CNT_INIT;
          end else if (if_ce_i && buf_hit) begin
            if_inst_o  <= buf_data;
            if_valid_o <= 1'b1;
          end else if (if_ce_i) begin
            addr_q <= if_addr_i;
            cnt_q  <= CNT_INIT;
          end
        end
        MEM_ACC: begin
          if (last) begin
            if (!we_q) mem_data_o <= ram_data_i;
            mem_done_o <= 1'b1;
            served_q   <= 1'b1;
            if (if_ce_i) begin
              addr_q <= if_addr_i;
              cnt_q  <= CNT_INIT;
            end
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        IF_ACC: begin
          if (last) begin
            if_inst_o  <= ram_data_i;
            if_valid_o <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign stallreq_o = stall;
  assign ram_addr_o = (state_q != IDLE) ? addr_q : '0;
  assign ram_oe_o   = (state_q == IF_ACC) ||
                      (state_q == MEM_ACC && !we_q);
  assign ram_we_o   = (state_q == MEM_ACC) && we_q && !last;
  assign ram_data_o = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a timeline-based model.
// Honors MEM_ARB_FETCH_BUF_EN for the buffer scenarios.
module tb_mem_arbiter;

  localparam int W = 1;
`ifdef MEM_ARB_FETCH_BUF_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        if_ce_i;
  logic [15:0] if_addr_i;
  logic [15:0] if_inst_o;
  logic        if_valid_o;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [15:0] mem_addr_i;
  logic [15:0] mem_data_i;
  logic [15:0] mem_data_o;
  logic        mem_done_o;
  logic        stallreq_o;
  logic [15:0] ram_addr_o;
  logic [15:0] ram_data_o;
  logic [15:0] ram_data_i;
  logic        ram_oe_o;
  logic        ram_we_o;

  always #5 clk = ~clk;

  mem_arbiter #(.WAIT_CYCLES(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_ce_i   (if_ce_i),
    .if_addr_i (if_addr_i),
    .if_inst_o (if_inst_o),
    .if_valid_o(if_valid_o),
    .mem_ce_i  (mem_ce_i),
    .mem_we_i  (mem_we_i),
    .mem_addr_i(mem_addr_i),
    .mem_data_i(mem_data_i),
    .mem_data_o(mem_data_o),
    .mem_done_o(mem_done_o),
    .stallreq_o(stallreq_o),
    .ram_addr_o(ram_addr_o),
    .ram_data_o(ram_data_o),
    .ram_data_i(ram_data_i),
    .ram_oe_o  (ram_oe_o),
    .ram_we_o  (ram_we_o)
  );

  // Small RAM: bit 15 plus low 7 address bits select a word.
  logic [15:0] ram [256];

  function automatic logic [7:0] ridx(logic [15:0] a);
    return {a[15], a[6:0]};
  endfunction

  assign ram_data_i = ram[ridx(ram_addr_o)];

  always @(posedge clk)
    if (ram_we_o) ram[ridx(ram_addr_o)] <= ram_data_o;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(string tag, logic [15:0] got, logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Model: an access is an address plus the cycle number it completes in.
  int          mcyc = 0;
  int          acc_end = -1;
  bit          acc_mem, acc_we;
  logic [15:0] acc_addr = '0;
  logic [15:0] m_wdata = '0;
  bit          served = 0;
  logic [15:0] e_if_inst = '0, e_mem_data = '0;
  bit          e_if_valid = 0, e_done = 0;
  bit          bvalid = 0;
  logic [15:0] baddr = '0, bdata = '0;

  int we_cnt, done_cnt, val_cnt, stall_cnt;

  task automatic clr();
    we_cnt = 0;
    done_cnt = 0;
    val_cnt = 0;
    stall_cnt = 0;
  endtask

  task automatic start(bit m, bit w, logic [15:0] a);
    acc_mem  = m;
    acc_we   = w;
    acc_addr = a;
    acc_end  = mcyc + 1 + W;
  endtask

  task automatic model_step();
    bit idle, pend, hit, x_stall, x_oe, x_we;
    int left;
    logic [15:0] x_addr, rd;
    idle = (acc_end < 0);
    pend = mem_ce_i && !served;
    left = acc_end - mcyc;
    hit  = 0;
    if (idle) begin
      x_addr = '0;
      x_oe   = 0;
      x_we   = 0;
      hit = BUF_EN && !pend && if_ce_i && bvalid && baddr == if_addr_i;
      x_stall = pend || (if_ce_i && !hit);
    end else begin
      x_addr  = acc_addr;
      x_oe    = !(acc_mem && acc_we);
      x_we    = acc_mem && acc_we && left != 0;
      x_stall = acc_mem || left != 0;
    end
    check("stallreq", 16'(stallreq_o), 16'(x_stall));
    check("ram_oe", 16'(ram_oe_o), 16'(x_oe));
    check("ram_we", 16'(ram_we_o), 16'(x_we));
    check("ram_addr", ram_addr_o, x_addr);
    check("ram_data_o", ram_data_o, m_wdata);
    check("if_valid", 16'(if_valid_o), 16'(e_if_valid));
    check("if_inst", if_inst_o, e_if_inst);
    check("mem_done", 16'(mem_done_o), 16'(e_done));
    check("mem_data", mem_data_o, e_mem_data);
    if (ram_we_o) we_cnt++;
    if (mem_done_o) done_cnt++;
    if (if_valid_o) val_cnt++;
    if (stallreq_o) stall_cnt++;
    e_if_valid = 0;
    e_done = 0;
    if (rst) begin
      acc_end = -1;
      served = 0;
      e_if_inst = '0;
      e_mem_data = '0;
      m_wdata = '0;
      bvalid = 0;
    end else begin
      if (!x_stall) served = 0;
      if (idle) begin
        if (pend) begin
          start(1, mem_we_i, mem_addr_i);
          m_wdata = mem_data_i;
        end else if (hit) begin
          e_if_inst = bdata;
          e_if_valid = 1;
        end else if (if_ce_i) begin
          start(0, 0, if_addr_i);
        end
      end else if (left == 0) begin
        rd = ram[ridx(acc_addr)];
        if (acc_mem) begin
          if (!acc_we) e_mem_data = rd;
          else if (bvalid && baddr == acc_addr) bvalid = 0;
          e_done = 1;
          served = 1;
          if (if_ce_i) start(0, 0, if_addr_i);
          else acc_end = -1;
        end else begin
          e_if_inst = rd;
          e_if_valid = 1;
          if (BUF_EN) begin
            bvalid = 1;
            baddr = acc_addr;
            bdata = rd;
          end
          acc_end = -1;
        end
      end
    end
    mcyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    rst = 0;
    if_ce_i = 0;
    mem_ce_i = 0;
    mem_we_i = 0;
  endtask

  task automatic fetch(logic [15:0] a, int hold);
    if_ce_i = 1;
    if_addr_i = a;
    repeat (hold) tick();
    if_ce_i = 0;
    repeat (2) tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 16'($urandom);
    ram[ridx(16'h0010)] = 16'h4A21;
    ram[ridx(16'h8000)] = 16'h1234;
    rst = 1;
    if_ce_i = 0;
    if_addr_i = '0;
    mem_ce_i = 0;
    mem_we_i = 0;
    mem_addr_i = '0;
    mem_data_i = '0;
    repeat (2) tick();
    idle_in();
    tick();

    // Single fetch
    clr();
    fetch(16'h0010, W + 2);
    check("fetch_stall_cycles", 16'(stall_cnt), 16'(W + 1));
    check("fetch_valid_pulses", 16'(val_cnt), 16'd1);
    check("fetch_inst", if_inst_o, 16'h4A21);

    // MEM read and fetch together
    clr();
    mem_ce_i = 1;
    mem_we_i = 0;
    mem_addr_i = 16'h8000;
    if_ce_i = 1;
    if_addr_i = 16'h0012;
    repeat (2 * W + 3) tick();
    idle_in();
    repeat (2) tick();
    check("both_stall_cycles", 16'(stall_cnt), 16'(2 * (W + 1)));
    check("both_done_pulses", 16'(done_cnt), 16'd1);
    check("both_valid_pulses", 16'(val_cnt), 16'd1);
    check("both_mem_data", mem_data_o, 16'h1234);

    // MEM write held through the trailing fetch
    clr();
    mem_ce_i = 1;
    mem_we_i = 1;
    mem_addr_i = 16'h8001;
    mem_data_i = 16'hBEEF;
    if_ce_i = 1;
    if_addr_i = 16'h0014;
    repeat (2 * W + 3) tick();
    idle_in();
    repeat (2) tick();
    check("write_we_cycles", 16'(we_cnt), 16'(W));
    check("write_done_pulses", 16'(done_cnt), 16'd1);
    check("write_ram", ram[ridx(16'h8001)], 16'hBEEF);

    // Reset in the middle of a fetch
    clr();
    if_ce_i = 1;
    if_addr_i = 16'h0030;
    repeat (2) tick();
    if_ce_i = 0;
    rst = 1;
    repeat (2) tick();
    rst = 0;
    repeat (3) tick();
    check("rst_valid_pulses", 16'(val_cnt), 16'd0);
    check("rst_inst", if_inst_o, 16'h0000);
    check("rst_oe", 16'(ram_oe_o), 16'd0);

`ifdef MEM_ARB_FETCH_BUF_EN
    fetch(16'h0020, W + 2);
    clr();
    fetch(16'h0020, 1);
    check("buf_hit_stall", 16'(stall_cnt), 16'd0);
    check("buf_hit_valid", 16'(val_cnt), 16'd1);
    mem_ce_i = 1;
    mem_we_i = 1;
    mem_addr_i = 16'h0020;
    mem_data_i = 16'h5A5A;
    repeat (W + 2) tick();
    idle_in();
    tick();
    clr();
    fetch(16'h0020, W + 2);
    check("buf_inval_stall", 16'(stall_cnt), 16'(W + 1));
    check("buf_inval_inst", if_inst_o, 16'h5A5A);
`endif

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      if_ce_i = ($urandom_range(0, 2) != 0);
      if_addr_i = 16'h0020 + 16'($urandom_range(0, 3));
      mem_ce_i = ($urandom_range(0, 2) == 0);
      mem_we_i = $urandom_range(0, 1) == 1;
      mem_addr_i = $urandom_range(0, 1) == 1 ?
                   16'h8000 + 16'($urandom_range(0, 3)) :
                   16'h0020 + 16'($urandom_range(0, 1));
      mem_data_i = 16'($urandom);
      tick();
    end
    idle_in();
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 1: extra RAM wait cycles per access; legal range 1..7; access length is WAIT_CYCLES+1 cycles.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 if_ce_i  in  1  fetch request from PC; if_addr_i  in  16  fetch address.
REQ-005 if_inst_o  out  16  fetched instruction; if_valid_o  out  1  one-cycle pulse, if_inst_o valid.
REQ-006 mem_ce_i  in  1  MEM-stage request; mem_we_i  in  1  1=write; mem_addr_i  in  16; mem_data_i  in  16  write data.
REQ-007 mem_data_o  out  16  read data; mem_done_o  out  1  one-cycle completion pulse.
REQ-008 stallreq_o  out  1  pipeline stall request to the stall controller, combinational.
REQ-009 ram_addr_o  out  16; ram_data_o  out  16; ram_data_i  in  16; ram_oe_o  out  1; ram_we_o  out  1; all RAM controls active-high.

Function
REQ-010 Single shared RAM; FSM states IDLE, MEM_ACC, IF_ACC; a 3-bit counter cnt tracks access progress.
REQ-011 Priority: MEM over IF, because MEM is the older instruction.
REQ-012 IDLE with mem_ce_i=1 and mem_served=0: go to MEM_ACC; latch addr/we/data; cnt<=WAIT_CYCLES.
REQ-013 IDLE otherwise, with if_ce_i=1: go to IF_ACC; latch if_addr_i; cnt<=WAIT_CYCLES.
REQ-014 In MEM_ACC and IF_ACC: cnt decrements each cycle; the access completes in the cycle where cnt==0.
REQ-015 MEM_ACC completion, read: mem_data_o<=ram_data_i.
REQ-016 MEM_ACC completion, any access: mem_done_o pulses; mem_served<=1; next state IF_ACC if if_ce_i=1, else IDLE.
REQ-017 IF_ACC completion: if_inst_o<=ram_data_i; if_valid_o pulses; next state IDLE.
REQ-018 ram_addr_o=latched address while busy, else 0.
REQ-019 ram_oe_o=1 during IF_ACC and MEM_ACC reads.
REQ-020 ram_we_o=1 during MEM_ACC write while cnt!=0; it deasserts in the completion cycle to give data hold time.
REQ-021 ram_data_o=latched write data.
REQ-022 stallreq_o=1 when:
  - state is IDLE and a request is pending (mem_ce_i&&!mem_served, or if_ce_i), or
  - state is MEM_ACC, or
  - state is IF_ACC and cnt!=0.
REQ-023 stallreq_o=0 in the IF_ACC completion cycle, so the pipeline advances exactly once per fetch.
REQ-024 mem_served clears on any cycle with stallreq_o=0, so the same held MEM request is never served twice.
REQ-025 mem_ce_i and if_ce_i both rising in IDLE: the MEM access runs first, then the fetch; total 2*(WAIT_CYCLES+1) cycles stalled.
REQ-026 Request inputs are sampled only in IDLE; changes during an access are ignored until the next IDLE decision.

Reset
REQ-027 rst=1 at a clock edge:
  - state<=IDLE, cnt<=0, mem_served<=0;
  - if_inst_o, mem_data_o <=0; if_valid_o, mem_done_o <=0.
REQ-028 rst during an access aborts it: no done/valid pulse is issued; ram_oe_o and ram_we_o are 0 from the next cycle.

Configuration
REQ-029 Macro MEM_ARB_FETCH_BUF_EN, when defined, adds a one-entry fetch buffer: buf_addr, buf_data, buf_valid.
REQ-030 With the macro, buffer fill: on each IF_ACC completion, buf_addr/buf_data are loaded and buf_valid<=1.
REQ-031 With the macro, buffer hit: in IDLE with no pending MEM request, if_ce_i=1 and buf_valid and buf_addr==if_addr_i:
  - if_inst_o<=buf_data and if_valid_o pulses;
  - stallreq_o=0 and the state stays IDLE.
REQ-032 With the macro, a MEM write to buf_addr clears buf_valid; reset clears buf_valid.
REQ-033 Without the macro, every fetch accesses the RAM and no buffer logic exists.

Structure
REQ-034 FSM state encodings and the RAM timing constant MEM_WAIT_DEFAULT belong in the shared defines file; bus widths reuse InstAddrBus/RegBus.
REQ-035 One sub-module is natural: mem_arb_fetch_buf, instantiated only under MEM_ARB_FETCH_BUF_EN.

Verification
REQ-036 Reset test: rst=1 for 2 cycles mid-IF_ACC -> all outputs 0, state IDLE, no if_valid_o pulse.
REQ-037 Fetch test, WAIT_CYCLES=1: if_ce_i=1, if_addr_i=0x0010, RAM returns 0x4A21 -> stallreq_o=1 for 2 cycles, 0 on the completion cycle; if_valid_o pulses; if_inst_o=0x4A21.
REQ-038 Simultaneous test: mem read at 0x8000 (RAM 0x1234) plus fetch at 0x0012:
  - mem_done_o pulses at cycle 2, mem_data_o=0x1234;
  - if_valid_o pulses at cycle 4;
  - stallreq_o falls only at cycle 4.
REQ-039 Write test: mem_we_i=1, addr 0x8001, data 0xBEEF -> ram_we_o=1 for exactly WAIT_CYCLES cycles with ram_data_o=0xBEEF; mem_done_o pulses once; mem_ce_i held through the trailing fetch does not trigger a second write.
REQ-040 Buffer test (macro on): fetch 0x0020 twice -> second fetch returns with no stall. Write 0x0020 then fetch 0x0020 -> RAM access occurs again (buffer invalidated).
